// File: rtl/hit_detector_pkg.sv
// hit_detector_pkg: shared types and defaults for the shooting-gallery hit
// detector.
//   state_t          - controller states IDLE / ARMED / DONE
//   DEF_*            - default parameter values
//   dbc_width()      - counter width able to hold 0..DEBOUNCE_CYCLES
package hit_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_NUM_TARGETS     = 10;
    localparam int DEF_SEL_W           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 50000000;
    localparam int DEF_TIME_W          = 26;

    function automatic int dbc_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hit_detector_debouncer.sv
// sensor_debouncer: one photo-sensor channel (already synchronised, 0 = light).
// Counts consecutive low samples while enabled and raises o_fire
// combinationally on the sample that completes DEBOUNCE_CYCLES lows. After
// firing, the channel stays quiet until it has seen a high sample.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_clear        - restart counting (new arm); overrides everything
//   i_enable       - count only while the detector is armed
//   i_sample       - synchronised sensor bit
//   o_fire         - qualifying low sample seen this cycle
module sensor_debouncer
    import hit_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_sample,
    output logic o_fire
);

    localparam int              CW   = dbc_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_fired;
    logic          w_last;

    // The counter holds the lows already seen; the current low sample is the
    // DEBOUNCE_CYCLES-th one when the count equals DEBOUNCE_CYCLES-1.
    assign w_last = (r_cnt == LAST);
    assign o_fire = i_enable & ~i_clear & ~i_sample & ~r_fired & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_fired <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_fired <= 1'b0;
        end else if (i_enable) begin
            if (i_sample) begin
                r_cnt   <= '0;
                r_fired <= 1'b0;
            end else if (!r_fired) begin
                if (w_last) begin
                    r_fired <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hit_detector.sv
// hit_detector: arms on one target of an NUM_TARGETS-wide active-low sensor
// array, debounces the selected sensor and reports a one-cycle hit or miss
// (timeout) with the reaction time in cycles.
//   clock, reset_n   - clock, async active-low reset
//   arm              - one-cycle arm request for target_active
//   target_active    - target index, ignored when >= NUM_TARGETS
//   photo_array      - raw asynchronous sensors, 0 = light detected
//   busy             - high while ARMED
//   hit_pulse        - one cycle on a debounced hit
//   miss_pulse       - one cycle on timeout
//   active_is_hit    - level, set by a hit, cleared by the next accepted arm
//   reaction_time    - cycles from arm acceptance to the qualifying sample
//   wrong_hit_pulse  - non-selected channel debounced low
// Optional macro HIT_DETECTOR_WRONG_TARGET_EN: per-channel debouncers and
// wrong_hit_pulse; without it only the selected channel is debounced and
// wrong_hit_pulse is tied 0.
module hit_detector
    import hit_detector_pkg::*;
#(
    parameter int NUM_TARGETS     = DEF_NUM_TARGETS,
    parameter int SEL_W           = DEF_SEL_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TIME_W          = DEF_TIME_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic [SEL_W-1:0]       target_active,
    input  logic [NUM_TARGETS-1:0] photo_array,
    output logic                   busy,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   active_is_hit,
    output logic [TIME_W-1:0]      reaction_time,
    output logic                   wrong_hit_pulse
);

    localparam logic [SEL_W:0]    LP_NUM = (SEL_W + 1)'(NUM_TARGETS);
    localparam logic [TIME_W-1:0] LP_TMO = TIME_W'(TIMEOUT_CYCLES);

    state_t                   r_state, w_state_nxt;
    logic [NUM_TARGETS-1:0]   r_sync1, r_sync2;
    logic [SEL_W-1:0]         r_sel;
    logic [TIME_W-1:0]        r_timer;
    logic [TIME_W-1:0]        r_reaction;
    logic                     r_hit_pulse, r_miss_pulse, r_active_hit;

    logic                     w_arm_ok, w_armed, w_sel_fire, w_hit, w_timeout;
    logic [TIME_W-1:0]        w_timer_inc;

    // Sensors idle high, so the synchroniser resets to all ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= photo_array;
            r_sync2 <= r_sync1;
        end
    end

    // A valid arm is accepted in every state and outranks hit/timeout.
    assign w_arm_ok    = arm & ({1'b0, target_active} < LP_NUM);
    assign w_armed     = (r_state == ST_ARMED);
    assign w_timer_inc = r_timer + 1'b1;
    // Debouncer fire is already masked by the arm clear.
    assign w_hit       = w_armed & w_sel_fire;
    assign w_timeout   = w_armed & ~w_arm_ok & (w_timer_inc == LP_TMO);

`ifdef HIT_DETECTOR_WRONG_TARGET_EN
    logic [NUM_TARGETS-1:0] w_fire;
    logic [NUM_TARGETS-1:0] w_sel_mask;
    logic                   r_wrong_hit;

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_dbc
        sensor_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_dbc (
            .i_clk    (clock),
            .i_rst_n  (reset_n),
            .i_clear  (w_arm_ok),
            .i_enable (w_armed),
            .i_sample (r_sync2[g]),
            .o_fire   (w_fire[g])
        );
    end

    assign w_sel_mask = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << r_sel;
    assign w_sel_fire = |(w_fire & w_sel_mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_wrong_hit <= 1'b0;
        else          r_wrong_hit <= |(w_fire & ~w_sel_mask);
    end
    assign wrong_hit_pulse = r_wrong_hit;
`else
    sensor_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbc (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_clear  (w_arm_ok),
        .i_enable (w_armed),
        .i_sample (r_sync2[r_sel]),
        .o_fire   (w_sel_fire)
    );
    assign wrong_hit_pulse = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_arm_ok) w_state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (w_arm_ok)                w_state_nxt = ST_ARMED;
                else if (w_hit || w_timeout) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = w_arm_ok ? ST_ARMED : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel        <= '0;
            r_timer      <= '0;
            r_reaction   <= '0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_active_hit <= 1'b0;
        end else begin
            r_hit_pulse  <= w_hit;
            // Hit wins a same-cycle race with the timeout.
            r_miss_pulse <= w_timeout & ~w_hit;
            if (w_arm_ok) begin
                r_sel        <= target_active;
                r_timer      <= '0;
                r_reaction   <= '0;
                r_active_hit <= 1'b0;
            end else if (w_armed) begin
                // Leaving ARMED at TIMEOUT_CYCLES freezes the timer, so no wrap.
                r_timer <= w_timer_inc;
                if (w_hit) begin
                    r_active_hit <= 1'b1;
                    r_reaction   <= w_timer_inc;
                end
            end
        end
    end

    assign busy          = w_armed;
    assign hit_pulse     = r_hit_pulse;
    assign miss_pulse    = r_miss_pulse;
    assign active_is_hit = r_active_hit;
    assign reaction_time = r_reaction;

endmodule
